// File: rtl/mmio_uart_tx_responder_if.sv
// MMIO peripheral bus bundle between the CPU-side decoder and the UART TX responder.
interface mmio_uart_tx_responder_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata,
    input  pready
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata,
    output pready
  );
endinterface

// File: rtl/mmio_uart_tx_responder.sv
// UART 8N1 transmitter behind the MMIO bus: TXDATA pushes into a small FIFO, STATUS polls it.
module mmio_uart_tx_responder #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  mmio_uart_tx_responder_if.slave     bus,
  output logic                        tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;

  // Serialiser state
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;
  logic [2:0]    bit_nxt;

  // Bus decode
  logic          access;
  logic          wr_txdata;
  logic          rd_status;
  logic          push, pop;
  logic [31:0]   count_ext;
  logic [31:0]   status;

  logic          unused_bits;
  assign unused_bits = ^{bus.pwdata[31:8], bus.paddr[1:0]};

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign access    = bus.psel & bus.penable;
  assign wr_txdata = access & bus.pwrite & (bus.paddr[3:2] == REG_TXDATA);
  assign rd_status = access & ~bus.pwrite & (bus.paddr[3:2] == REG_STATUS);
  assign push      = wr_txdata & ~full;

  // Only a TXDATA write can stall; full is registered so a freed slot shows up a cycle later.
  assign bus.pready = access & (~wr_txdata | ~full);

  assign count_ext = 32'(count_q);
  assign status    = {25'd0, count_ext[2:0], 1'b0, (state_q != ST_IDLE), empty, full};

  always_comb begin
    bus.prdata = 32'd0;
    if (rd_status) begin
      bus.prdata = status;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.pwdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// Randomised bench for mmio_uart_tx_responder against a queue-and-frame-timer reference model.
module tb_mmio_uart_tx_responder;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic reset;
  logic tx;

  mmio_uart_tx_responder_if bus ();

  mmio_uart_tx_responder #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes waiting, and position within the frame on the wire (-1 = idle line).
  logic [7:0] q[$];
  int         pos;
  logic [7:0] cur;
  logic       last_pready;
  logic [31:0] last_prdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  function automatic logic [31:0] status_val();
    int n;
    n = q.size();
    return {25'd0, 3'(n), 1'b0, (pos >= 0), (n == 0), (n == DEPTH)};
  endfunction

  // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    logic acc, wr_tx, m_pready, m_push, m_pop;
    logic [31:0] m_rd;
    @(negedge clk);
    acc      = bus.psel && bus.penable;
    wr_tx    = acc && bus.pwrite && (bus.paddr[3:2] == 2'd0);
    m_pready = acc && (!wr_tx || q.size() < DEPTH);
    m_rd     = (acc && !bus.pwrite && bus.paddr[3:2] == 2'd1) ? status_val() : 32'd0;
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("pready", {31'd0, bus.pready}, {31'd0, m_pready});
    check("prdata", bus.prdata, m_rd);
    last_pready = m_pready;
    last_prdata = bus.prdata;
    m_push = wr_tx && q.size() < DEPTH;
    m_pop  = (pos < 0) && q.size() > 0;
    @(posedge clk);
    if (reset) begin
      q.delete();
      pos = -1;
    end else begin
      if (pos >= 0) begin
        pos++;
        if (pos == FRAME) pos = -1;
      end
      if (m_pop) begin
        cur = q.pop_front();
        pos = 0;
      end
      if (m_push) q.push_back(bus.pwdata[7:0]);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output int waits);
    bit done;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    step();
    bus.penable = 1'b1;
    done  = 1'b0;
    waits = 0;
    while (!done && waits < 200) begin
      step();
      done = last_pready;
      if (!done) waits++;
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    rd          = last_prdata;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  logic [31:0] rd;
  int          waits;
  int          guard;

  initial begin
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 4'd0;
    bus.pwdata  = 32'd0;
    reset       = 1'b1;
    pos         = -1;
    cur         = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Idle after reset
    idle(20);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_pready", {31'd0, bus.pready}, 32'd0);
    xfer(1'b0, 4'h4, 32'd0, rd, waits);
    check("status_reset", rd, 32'h2);

    // Single byte
    xfer(1'b1, 4'h0, 32'h55, rd, waits);
    check("w55_waits", waits, 0);
    step();
    check("start_bit", {31'd0, tx}, 32'd0);
    xfer(1'b0, 4'h4, 32'd0, rd, waits);
    check("busy_in_frame", rd & 32'h4, 32'h4);
    idle(FRAME + 4);
    xfer(1'b0, 4'h4, 32'd0, rd, waits);
    check("status_after_frame", rd, 32'h2);

    // Six back-to-back writes; the sixth stalls on full
    for (int i = 1; i <= 6; i++) begin
      xfer(1'b1, 4'h0, 32'(i), rd, waits);
      if (i <= 5) check("b2b_nowait", waits, 0);
      else        check("b2b_w6_stall", {31'd0, waits > 0}, 32'd1);
    end
    idle(6 * (FRAME + 1) + 10);

    // Full FIFO, then reads and ignored writes
    for (int i = 0; i < 5; i++) xfer(1'b1, 4'h0, 32'hA0 + 32'(i), rd, waits);
    xfer(1'b0, 4'h4, 32'd0, rd, waits);
    check("full_status_wait", waits, 0);
    check("full_status", rd & 32'h71, 32'h41);
    xfer(1'b1, 4'h4, 32'hFF, rd, waits);
    check("wr_status_nowait", waits, 0);
    xfer(1'b1, 4'hC, 32'hFF, rd, waits);
    check("wr_unmapped_nowait", waits, 0);
    idle(5 * (FRAME + 1) + 10);

    // Reset during data bit 3 with bytes queued
    for (int i = 0; i < 3; i++) xfer(1'b1, 4'h0, 32'h3C + 32'(i), rd, waits);
    guard = 0;
    while (pos != 4 * CPB + 1 && guard < 500) begin
      step();
      guard++;
    end
    check("reach_bit3", {31'd0, guard < 500}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_tx_high", {31'd0, tx}, 32'd1);
    idle(3 * FRAME);
    xfer(1'b0, 4'h4, 32'd0, rd, waits);
    check("status_after_rst", rd, 32'h2);

    // Reads of write-only / unmapped, and a setup-only cycle
    xfer(1'b0, 4'h0, 32'd0, rd, waits);
    check("rd_txdata", rd, 32'd0);
    xfer(1'b0, 4'h8, 32'd0, rd, waits);
    check("rd_unmapped", rd, 32'd0);
    bus.psel   = 1'b1;
    bus.pwrite = 1'b1;
    bus.paddr  = 4'h0;
    bus.pwdata = 32'h77;
    step();
    bus.psel = 1'b0;
    idle(3);
    xfer(1'b0, 4'h4, 32'd0, rd, waits);
    check("setup_only_no_push", rd, 32'h2);

    // Randomised traffic
    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        xfer(1'b1, {2'b00, 2'($urandom)}, $urandom, rd, waits);
      end else if (op <= 6) begin
        xfer(1'b0, {2'b01, 2'($urandom)}, $urandom, rd, waits);
      end else if (op == 7) begin
        xfer(1'($urandom), {1'b1, 3'($urandom)}, $urandom, rd, waits);
      end else if (op == 8) begin
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'($urandom);
        bus.paddr   = 4'($urandom);
        bus.pwdata  = $urandom;
        step();
        if ($urandom_range(0, 1) == 1) begin
          bus.penable = 1'b1;
          step();
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
      end else begin
        idle($urandom_range(0, 15));
      end
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end
    idle(DEPTH * (FRAME + 1) + 2 * FRAME);
    check("final_tx_idle", {31'd0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
